// File: rtl/ultra_seg_scan_pkg.sv
// Shared display definitions: digit count, active-high glyphs {g,f,e,d,c,b,a},
// the frame snapshot record and the slot-to-anode helper.
package ultra_seg_scan_pkg;

    localparam int unsigned DIGITS = 4;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_A     = 7'h77;
    localparam logic [6:0] SEG_B     = 7'h7C;  // lower-case b
    localparam logic [6:0] SEG_C     = 7'h39;
    localparam logic [6:0] SEG_D     = 7'h5E;  // lower-case d
    localparam logic [6:0] SEG_E     = 7'h79;
    localparam logic [6:0] SEG_F     = 7'h71;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Everything the display needs for one frame, captured together so a frame never tears.
    typedef struct packed {
        logic [DIGITS-1:0][3:0] digit;
        logic [DIGITS-1:0]      dp_mask;
        logic                   blank_lz;
        logic [2:0]             bright;
    } snap_t;

    // Active-high one-hot anode pattern for a slot index.
    function automatic logic [DIGITS-1:0] slot_onehot(input logic [1:0] idx);
        slot_onehot = 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/ultra_seg_scan_hex7seg.sv
// Combinational hex nibble to active-high seven-segment glyph, with a blank override.
module ultra_hex7seg
    import ultra_seg_scan_pkg::*;
(
    input  logic [3:0] nib,
    input  logic       blank,
    output logic [6:0] seg
);

    // Glyph lookup; a blanked digit shows no segments.
    always_comb begin
        seg = SEG_BLANK;
        if (blank) begin
            seg = SEG_BLANK;
        end else begin
            case (nib)
                4'h0:    seg = SEG_0;
                4'h1:    seg = SEG_1;
                4'h2:    seg = SEG_2;
                4'h3:    seg = SEG_3;
                4'h4:    seg = SEG_4;
                4'h5:    seg = SEG_5;
                4'h6:    seg = SEG_6;
                4'h7:    seg = SEG_7;
                4'h8:    seg = SEG_8;
                4'h9:    seg = SEG_9;
                4'hA:    seg = SEG_A;
                4'hB:    seg = SEG_B;
                4'hC:    seg = SEG_C;
                4'hD:    seg = SEG_D;
                4'hE:    seg = SEG_E;
                4'hF:    seg = SEG_F;
                default: seg = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/ultra_seg_scan.sv
// Four-digit multiplexed seven-segment scan driver: slot divider, frame snapshot,
// leading-zero blanking, brightness window with dead time, registered outputs.
module ultra_seg_scan
    import ultra_seg_scan_pkg::*;
#(
    parameter int unsigned SLOT_DIV   = 50000,
    parameter int unsigned DEAD_CYC   = 64,
    parameter bit          SEG_ACT_LO = 1'b1,
    parameter bit          AN_ACT_LO  = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] digit0,
    input  logic [3:0] digit1,
    input  logic [3:0] digit2,
    input  logic [3:0] digit3,
    input  logic [3:0] dp_mask,
    input  logic       blank_lz,
    input  logic [2:0] bright,
    output logic [6:0] seg,
    output logic       dp,
    output logic [3:0] an,
    output logic       frame_tick
);

    localparam int unsigned    CNT_W    = $clog2(SLOT_DIV);
    localparam int unsigned    STEP     = SLOT_DIV / 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SLOT_DIV - 1);
    localparam logic [6:0]     SEG_OFF  = SEG_ACT_LO ? 7'h7F : 7'h00;
    localparam logic           DP_OFF   = SEG_ACT_LO;
    localparam logic [3:0]     AN_OFF   = AN_ACT_LO ? 4'hF : 4'h0;

    logic [CNT_W-1:0] cnt_r;
    logic [1:0]       idx_r;
    logic             first_r;
    snap_t            snap_r;
    logic [6:0]       seg_r;
    logic             dp_r;
    logic [3:0]       an_r;
    logic             frame_tick_r;

    logic             slot_end_s;
    logic             snap_s;
    logic [31:0]      lim_s;
    logic             lit_s;
    logic             blk3_s;
    logic             blk2_s;
    logic             blk1_s;
    logic             blank_s;
    logic [3:0]       nib_s;
    logic [6:0]       seg_hi_s;
    logic             dp_hi_s;
    logic [3:0]       an_hi_s;

    // Slot end and frame boundary; the first cycle out of reset also takes a snapshot.
    always_comb begin
        slot_end_s = (cnt_r == CNT_LAST);
        snap_s     = first_r || (slot_end_s && (idx_r == 2'd3));
    end

    // Slot divider and digit index.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_r <= '0;
            idx_r <= 2'd0;
        end else if (slot_end_s) begin
            cnt_r <= '0;
            idx_r <= idx_r + 2'd1;
        end else begin
            cnt_r <= cnt_r + CNT_W'(1);
            idx_r <= idx_r;
        end
    end

    // Marks the first cycle after reset release.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            first_r <= 1'b1;
        end else begin
            first_r <= 1'b0;
        end
    end

    // Frame snapshot: all display inputs captured together at the frame boundary.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            snap_r <= '0;
        end else if (snap_s) begin
            snap_r <= '{digit:    {digit3, digit2, digit1, digit0},
                        dp_mask:  dp_mask,
                        blank_lz: blank_lz,
                        bright:   bright};
        end else begin
            snap_r <= snap_r;
        end
    end

    // Lit window: past the dead time and inside the brightness fraction of the slot.
    always_comb begin
        lim_s = (32'(snap_r.bright) + 32'd1) * STEP;
        lit_s = 1'b0;
        if (first_r) begin
            lit_s = 1'b0;
        end else if ((32'(cnt_r) >= DEAD_CYC) && (32'(cnt_r) < lim_s)) begin
            lit_s = 1'b1;
        end else begin
            lit_s = 1'b0;
        end
    end

    // Leading-zero blanking chain from the leftmost digit, and per-slot selection.
    always_comb begin
        blk3_s  = snap_r.blank_lz && (snap_r.digit[3] == 4'h0);
        blk2_s  = blk3_s && (snap_r.digit[2] == 4'h0);
        blk1_s  = blk2_s && (snap_r.digit[1] == 4'h0);
        nib_s   = snap_r.digit[idx_r];
        dp_hi_s = snap_r.dp_mask[idx_r];
        blank_s = 1'b0;
        case (idx_r)
            2'd0:    blank_s = 1'b0;
            2'd1:    blank_s = blk1_s;
            2'd2:    blank_s = blk2_s;
            2'd3:    blank_s = blk3_s;
            default: blank_s = 1'b0;
        endcase
        an_hi_s = 4'b0000;
        if (lit_s) begin
            an_hi_s = slot_onehot(idx_r);
        end else begin
            an_hi_s = 4'b0000;
        end
    end

    ultra_hex7seg u_hex7seg (
        .nib   (nib_s),
        .blank (blank_s),
        .seg   (seg_hi_s)
    );

    // Output registers with polarity applied; one clock behind the scan state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            seg_r        <= SEG_OFF;
            dp_r         <= DP_OFF;
            an_r         <= AN_OFF;
            frame_tick_r <= 1'b0;
        end else begin
            seg_r        <= SEG_ACT_LO ? ~seg_hi_s : seg_hi_s;
            dp_r         <= SEG_ACT_LO ? ~dp_hi_s : dp_hi_s;
            an_r         <= AN_ACT_LO ? ~an_hi_s : an_hi_s;
            frame_tick_r <= snap_s;
        end
    end

    assign seg        = seg_r;
    assign dp         = dp_r;
    assign an         = an_r;
    assign frame_tick = frame_tick_r;

endmodule
